// File: rtl/hovalaag_driver.sv
`default_nettype none
// ============================================================================
// hovalaag_driver : host-side bus master that serialises one instruction and
// its IN1/IN2 operands onto the wrapper pins, fires one EXEC, reads results.
// Optional debug read-back of A-D enabled by defining HOV_DRV_DEBUG_EN.
// Revision: 1.0
// ============================================================================
module hovalaag_driver #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [31:0] i_instr,
  input  logic [11:0] i_in1,
  input  logic [11:0] i_in2,
  output logic [9:0]  o_addr,
  output logic [5:0]  o_io_in,
  input  logic [7:0]  i_io_out,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_status,
  output logic [7:0]  o_pc,
  output logic [11:0] o_out
`ifdef HOV_DRV_DEBUG_EN
  ,
  output logic [7:0]  o_dbg_a,
  output logic [7:0]  o_dbg_b,
  output logic [7:0]  o_dbg_c,
  output logic [7:0]  o_dbg_d
`endif
);

  localparam logic [3:0] c_HOLD_RELOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [4:0] c_EXEC_IDX    = 5'd9;
`ifdef HOV_DRV_DEBUG_EN
  localparam logic [4:0] c_LAST_IDX    = 5'd16;
`else
  localparam logic [4:0] c_LAST_IDX    = 5'd12;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PHASE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // 1-hot wrapper select for each phase index.
  function automatic logic [9:0] f_phase_addr(input logic [4:0] idx);
    logic [9:0] a;
    a = '0;
    case (idx)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4: a = 10'd1 << idx;
      5'd5, 5'd10:                  a = 10'h040;
      5'd6, 5'd11:                  a = 10'h080;
      5'd7, 5'd12:                  a = 10'h100;
      5'd8:                         a = 10'h200;
      5'd9:                         a = 10'h020;
`ifdef HOV_DRV_DEBUG_EN
      5'd13, 5'd14, 5'd15, 5'd16:   a = 10'd1 << (idx - 5'd13);
`endif
      default:                      a = '0;
    endcase
    return a;
  endfunction

  function automatic logic [5:0] f_phase_data(input logic [4:0]  idx,
                                              input logic [31:0] instr,
                                              input logic [11:0] in1,
                                              input logic [11:0] in2);
    logic [5:0] d;
    d = '0;
    case (idx)
      5'd0:         d = instr[5:0];
      5'd1:         d = instr[11:6];
      5'd2:         d = instr[17:12];
      5'd3:         d = instr[23:18];
      5'd4:         d = instr[29:24];
      5'd5, 5'd10:  d = in1[5:0];
      5'd6, 5'd11:  d = in1[11:6];
      5'd7, 5'd12:  d = in2[5:0];
      5'd8:         d = in2[11:6];
      5'd9:         d = {4'b0000, instr[31:30]};
`ifdef HOV_DRV_DEBUG_EN
      5'd13:        d = instr[5:0];
      5'd14:        d = instr[11:6];
      5'd15:        d = instr[17:12];
      5'd16:        d = instr[23:18];
`endif
      default:      d = '0;
    endcase
    return d;
  endfunction

  state_t      r_state;
  logic [4:0]  r_idx;
  logic [3:0]  r_hold;
  logic [31:0] r_instr;
  logic [11:0] r_in1;
  logic [11:0] r_in2;
  logic [9:0]  r_addr;
  logic [5:0]  r_io_in;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_status;
  logic [7:0]  r_pc;
  logic [11:0] r_out;
  logic [3:0]  r_stg_status;
  logic [7:0]  r_stg_pc;
  logic [7:0]  r_stg_out_lo;
`ifdef HOV_DRV_DEBUG_EN
  logic [3:0]  r_stg_out_hi;
  logic [7:0]  r_stg_dbg_a;
  logic [7:0]  r_stg_dbg_b;
  logic [7:0]  r_stg_dbg_c;
  logic [7:0]  r_dbg_a;
  logic [7:0]  r_dbg_b;
  logic [7:0]  r_dbg_c;
  logic [7:0]  r_dbg_d;
`endif

  logic [4:0] w_next_idx;
  assign w_next_idx = r_idx + 5'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_hold       <= '0;
      r_instr      <= '0;
      r_in1        <= '0;
      r_in2        <= '0;
      r_addr       <= '0;
      r_io_in      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_status     <= '0;
      r_pc         <= '0;
      r_out        <= '0;
      r_stg_status <= '0;
      r_stg_pc     <= '0;
      r_stg_out_lo <= '0;
`ifdef HOV_DRV_DEBUG_EN
      r_stg_out_hi <= '0;
      r_stg_dbg_a  <= '0;
      r_stg_dbg_b  <= '0;
      r_stg_dbg_c  <= '0;
      r_dbg_a      <= '0;
      r_dbg_b      <= '0;
      r_dbg_c      <= '0;
      r_dbg_d      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= S_PHASE;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_hold  <= c_HOLD_RELOAD;
            r_instr <= i_instr;
            r_in1   <= i_in1;
            r_in2   <= i_in2;
            r_addr  <= f_phase_addr(5'd0);
            r_io_in <= f_phase_data(5'd0, i_instr, i_in1, i_in2);
          end else begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_io_in <= '0;
          end
        end
        S_PHASE: begin
          if (r_hold != 4'd0) begin
            r_hold <= r_hold - 4'd1;
          end else begin
            // Last edge of the phase: capture read-back data into staging.
            case (r_idx)
              5'd9:  r_stg_status <= i_io_out[3:0];
              5'd10: r_stg_pc     <= i_io_out;
              5'd11: r_stg_out_lo <= i_io_out;
`ifdef HOV_DRV_DEBUG_EN
              5'd12: r_stg_out_hi <= i_io_out[3:0];
              5'd13: r_stg_dbg_a  <= i_io_out;
              5'd14: r_stg_dbg_b  <= i_io_out;
              5'd15: r_stg_dbg_c  <= i_io_out;
`endif
              default: ;
            endcase
            if (r_idx == c_LAST_IDX) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_addr   <= '0;
              r_io_in  <= '0;
              r_status <= r_stg_status;
              r_pc     <= r_stg_pc;
`ifdef HOV_DRV_DEBUG_EN
              r_out    <= {r_stg_out_hi, r_stg_out_lo};
              r_dbg_a  <= r_stg_dbg_a;
              r_dbg_b  <= r_stg_dbg_b;
              r_dbg_c  <= r_stg_dbg_c;
              r_dbg_d  <= i_io_out;
`else
              r_out    <= {i_io_out[3:0], r_stg_out_lo};
`endif
            end else begin
              r_idx   <= w_next_idx;
              // EXEC gates the CPU clock, so it never stretches.
              r_hold  <= (w_next_idx == c_EXEC_IDX) ? 4'd0 : c_HOLD_RELOAD;
              r_addr  <= f_phase_addr(w_next_idx);
              r_io_in <= f_phase_data(w_next_idx, r_instr, r_in1, r_in2);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_addr  <= '0;
          r_io_in <= '0;
        end
      endcase
    end
  end

  assign o_addr   = r_addr;
  assign o_io_in  = r_io_in;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_status = r_status;
  assign o_pc     = r_pc;
  assign o_out    = r_out;
`ifdef HOV_DRV_DEBUG_EN
  assign o_dbg_a  = r_dbg_a;
  assign o_dbg_b  = r_dbg_b;
  assign o_dbg_c  = r_dbg_c;
  assign o_dbg_d  = r_dbg_d;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hovalaag_driver.sv
`default_nettype none
// ============================================================================
// tb_hovalaag_driver : self-checking bench with a behavioural wrapper model,
// two DUTs (HOLD_CYCLES 1 and 3). Honours HOV_DRV_DEBUG_EN when defined.
// Revision: 1.0
// ============================================================================
module tb_hovalaag_driver;

`ifdef HOV_DRV_DEBUG_EN
  localparam int PH_N = 17;
`else
  localparam int PH_N = 13;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [11:0] in1;
    logic [11:0] in2;
    logic [3:0]  st;
    logic [7:0]  pc;
    logic [11:0] out;
    logic [7:0]  da;
    logic [7:0]  db;
    logic [7:0]  dc;
    logic [7:0]  dd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start  [2];
  logic [31:0] instr  [2];
  logic [11:0] in1    [2];
  logic [11:0] in2    [2];
  logic [9:0]  addr   [2];
  logic [5:0]  io_in  [2];
  logic [7:0]  io_out [2];
  logic        busy   [2];
  logic        done   [2];
  logic [3:0]  status [2];
  logic [7:0]  pc     [2];
  logic [11:0] outv   [2];
`ifdef HOV_DRV_DEBUG_EN
  logic [7:0]  dbg_a  [2];
  logic [7:0]  dbg_b  [2];
  logic [7:0]  dbg_c  [2];
  logic [7:0]  dbg_d  [2];
`endif

  for (genvar k = 0; k < 2; k++) begin : g_dut
    hovalaag_driver #(.HOLD_CYCLES(k == 0 ? 1 : 3)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_start  (start[k]),
      .i_instr  (instr[k]),
      .i_in1    (in1[k]),
      .i_in2    (in2[k]),
      .o_addr   (addr[k]),
      .o_io_in  (io_in[k]),
      .i_io_out (io_out[k]),
      .o_busy   (busy[k]),
      .o_done   (done[k]),
      .o_status (status[k]),
      .o_pc     (pc[k]),
      .o_out    (outv[k])
`ifdef HOV_DRV_DEBUG_EN
      ,
      .o_dbg_a  (dbg_a[k]),
      .o_dbg_b  (dbg_b[k]),
      .o_dbg_c  (dbg_c[k]),
      .o_dbg_d  (dbg_d[k])
`endif
    );
  end

  // Wrapper model: registers written through addr/io_in, a CPU that
  // "executes" on each clock with addr[5] and then exposes its results.
  vec_t        rsp     [2];
  logic [31:0] m_instr [2];
  logic [11:0] m_in1   [2];
  logic [11:0] m_in2   [2];
  int          exec_cnt[2];
  logic [7:0]  w_pc    [2];
  logic [11:0] w_out   [2];
  logic [7:0]  w_a [2], w_b [2], w_c [2], w_d [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      exec_cnt[k] = 0;
      m_instr[k] = '0; m_in1[k] = '0; m_in2[k] = '0;
      w_pc[k] = 8'h00; w_out[k] = 12'h000;
      w_a[k] = 8'h00; w_b[k] = 8'h00; w_c[k] = 8'h00; w_d[k] = 8'h00;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (addr[k][0]) m_instr[k][5:0]   <= io_in[k];
      if (addr[k][1]) m_instr[k][11:6]  <= io_in[k];
      if (addr[k][2]) m_instr[k][17:12] <= io_in[k];
      if (addr[k][3]) m_instr[k][23:18] <= io_in[k];
      if (addr[k][4]) m_instr[k][29:24] <= io_in[k];
      if (addr[k][6]) m_in1[k][5:0]     <= io_in[k];
      if (addr[k][7]) m_in1[k][11:6]    <= io_in[k];
      if (addr[k][8]) m_in2[k][5:0]     <= io_in[k];
      if (addr[k][9]) m_in2[k][11:6]    <= io_in[k];
      if (addr[k][5]) begin
        m_instr[k][31:30] <= io_in[k][1:0];
        exec_cnt[k] <= exec_cnt[k] + 1;
        w_pc[k]  <= rsp[k].pc;
        w_out[k] <= rsp[k].out;
        w_a[k] <= rsp[k].da; w_b[k] <= rsp[k].db;
        w_c[k] <= rsp[k].dc; w_d[k] <= rsp[k].dd;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      io_out[k] = 8'h00;
      if (addr[k][5])      io_out[k] = {4'hA, rsp[k].st};
      else if (addr[k][6]) io_out[k] = w_pc[k];
      else if (addr[k][7]) io_out[k] = w_out[k][7:0];
      else if (addr[k][8]) io_out[k] = {4'h6, w_out[k][11:8]};
      else if (addr[k][0]) io_out[k] = w_a[k];
      else if (addr[k][1]) io_out[k] = w_b[k];
      else if (addr[k][2]) io_out[k] = w_c[k];
      else if (addr[k][3]) io_out[k] = w_d[k];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] exp_addr(input int p);
    int bitpos [17] = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 5, 6, 7, 8, 0, 1, 2, 3};
    return 10'(1) << bitpos[p];
  endfunction

  function automatic logic [5:0] exp_io(input int p, input vec_t v);
    case (p)
      0, 1, 2, 3, 4: return 6'(v.instr >> (6 * p));
      5, 10:         return v.in1[5:0];
      6, 11:         return v.in1[11:6];
      7, 12:         return v.in2[5:0];
      8:             return v.in2[11:6];
      9:             return 6'(v.instr >> 30);
      default:       return 6'(v.instr >> (6 * (p - 13)));
    endcase
  endfunction

  function automatic int txn_len(input int k);
    return (PH_N - 1) * ((k == 0) ? 1 : 3) + 1;
  endfunction

  task automatic launch(input int k, input vec_t v);
    @(negedge clk);
    rsp[k]   = v;
    instr[k] = v.instr;
    in1[k]   = v.in1;
    in2[k]   = v.in2;
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    instr[k] = $urandom;
    in1[k]   = 12'($urandom);
    in2[k]   = 12'($urandom);
  endtask

  // Called just after the accepting edge; walks the whole bus trace.
  task automatic expect_txn(input int k, input vec_t v, input int pulse_at,
                            input bit post_idle, input string tag);
    logic [15:0] q[$];
    int hold;
    int ex0;
    hold = (k == 0) ? 1 : 3;
    ex0  = exec_cnt[k];
    for (int p = 0; p < PH_N; p++)
      for (int r = 0; r < ((p == 9) ? 1 : hold); r++)
        q.push_back({exp_addr(p), exp_io(p, v)});
    for (int c = 1; c <= q.size(); c++) begin
      @(negedge clk);
      check($sformatf("%s trace c%0d", tag, c), {busy[k], done[k], addr[k], io_in[k]}, {2'b10, q[c-1]});
      if (c == pulse_at) begin
        start[k] = 1'b1;
        instr[k] = $urandom;
        in1[k]   = 12'($urandom);
      end else if (c == pulse_at + 1) begin
        start[k] = 1'b0;
      end
    end
    @(negedge clk);
    check($sformatf("%s done cycle %0d", tag, q.size() + 1), {busy[k], done[k], addr[k], io_in[k]}, {2'b01, 16'h0});
    check($sformatf("%s results", tag), {status[k], pc[k], outv[k]}, {v.st, v.pc, v.out});
`ifdef HOV_DRV_DEBUG_EN
    check($sformatf("%s dbg", tag), {dbg_a[k], dbg_b[k], dbg_c[k], dbg_d[k]}, {v.da, v.db, v.dc, v.dd});
`endif
    check($sformatf("%s exec count", tag), 64'(exec_cnt[k] - ex0), 64'd1);
    check($sformatf("%s wrapper regs", tag), {m_instr[k], m_in1[k], m_in2[k]}, {v.instr, v.in1, v.in2});
    if (post_idle) begin
      @(negedge clk);
      check($sformatf("%s idle after", tag), {busy[k], done[k], addr[k], io_in[k]}, 18'h0);
      check($sformatf("%s results hold", tag), {status[k], pc[k], outv[k]}, {v.st, v.pc, v.out});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    vec_t v;
    vec_t vb;
    int   k;
    int   pa;
    int   bad;
    int   ex0;
    bit   found;

    tbl[0] = '{32'hC0004123, 12'hABC, 12'h555, 4'h5, 8'h17, 12'h9A3, 8'h11, 8'h22, 8'h33, 8'h44};
    tbl[1] = '{32'h00000000, 12'h000, 12'h000, 4'h0, 8'h00, 12'h000, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{32'hFFFFFFFF, 12'hFFF, 12'hFFF, 4'hF, 8'hFF, 12'hFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[3] = '{32'h8A5C3E71, 12'h123, 12'hFED, 4'hA, 8'h5C, 12'h6B1, 8'hA1, 8'hB2, 8'hC3, 8'hD4};

    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; instr[i] = '0; in1[i] = '0; in2[i] = '0;
      rsp[i] = tbl[1];
    end
    repeat (2) @(negedge clk);
    start[0] = 1'b1; start[1] = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset bus d%0d", i), {busy[i], done[i], addr[i], io_in[i]}, 18'h0);
      check($sformatf("reset results d%0d", i), {status[i], pc[i], outv[i]}, 24'h0);
    end
    start[0] = 1'b0; start[1] = 1'b0;
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if ({busy[i], done[i], addr[i], io_in[i]} != 18'h0) bad++;
    end
    check("idle 20 cycles nonzero count", 64'(bad), 64'd0);

    for (int i = 0; i < 4; i++) begin
      launch(0, tbl[i]);
      expect_txn(0, tbl[i], -1, 1'b1, $sformatf("tbl%0d", i));
    end
    launch(1, tbl[0]);
    expect_txn(1, tbl[0], -1, 1'b1, "hold3");

    // start pulsed in phase 4 must be ignored.
    launch(0, tbl[3]);
    expect_txn(0, tbl[3], 5, 1'b1, "pulse_p4");

    // start held high through DONE: second transaction right after.
    v  = tbl[0];
    vb = tbl[3];
    @(negedge clk);
    rsp[0] = v; instr[0] = v.instr; in1[0] = v.in1; in2[0] = v.in2; start[0] = 1'b1;
    @(posedge clk);
    #1;
    instr[0] = vb.instr; in1[0] = vb.in1; in2[0] = vb.in2;
    expect_txn(0, v, -1, 1'b0, "b2b_a");
    rsp[0] = vb;
    @(posedge clk);
    #1;
    start[0] = 1'b0; instr[0] = $urandom;
    expect_txn(0, vb, -1, 1'b1, "b2b_b");

    for (int i = 0; i < 16; i++) begin
      k = i % 2;
      v.instr = $urandom;
      v.in1 = 12'($urandom); v.in2 = 12'($urandom);
      v.st  = 4'($urandom);  v.pc  = 8'($urandom); v.out = 12'($urandom);
      v.da  = 8'($urandom);  v.db  = 8'($urandom);
      v.dc  = 8'($urandom);  v.dd  = 8'($urandom);
      pa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, txn_len(k) - 1)) : -1;
      launch(k, v);
      expect_txn(k, v, pa, 1'b1, $sformatf("rnd%0d", i));
    end

    // Reset asserted while EXEC is on the bus.
    launch(0, tbl[3]);
    expect_txn(0, tbl[3], -1, 1'b1, "pre_reset");
    launch(0, tbl[0]);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (addr[0][5]) begin
        found = 1'b1;
        break;
      end
    end
    check("reset reached exec", 64'(found), 64'd1);
    ex0 = exec_cnt[0];
    reset_n = 1'b0;
    #1;
    check("reset mid-exec bus", {busy[0], done[0], addr[0], io_in[0]}, 18'h0);
    check("reset mid-exec results", {status[0], pc[0], outv[0]}, 24'h0);
    @(posedge clk);
    #1;
    check("reset mid-exec no exec", 64'(exec_cnt[0] - ex0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    launch(0, tbl[2]);
    expect_txn(0, tbl[2], -1, 1'b1, "after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
